// File: rtl/rotation_pkg.sv
// Shared types and constants for the rotation/mode/frame-count control stage.
package rotation_pkg;

  typedef logic [5:0] deg_t;
  typedef logic [2:0] mode_t;
  typedef logic [6:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } step_state_e;

  // Millidegrees per angle LSB; the display decoder's x45>>3 conversion relies on it.
  localparam int unsigned DEG_STEP_MDEG = 5625;

endpackage

// File: rtl/rotation_ctrl_key_repeat.sv
// Angle-key edge detection with press-and-hold auto-repeat; emits a one-cycle step and its direction.
//   state  | meaning
//   IDLE   | no step key being tracked, waiting for a fresh press
//   HOLD   | first step taken, counting down the initial repeat delay
//   REPEAT | auto-repeating, one step every REPEAT_PERIOD cycles
module key_repeat
  import rotation_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_inc,
  input  logic key_dec,
  output logic step,
  output logic step_up
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW = $clog2(TMAX + 1);

  step_state_e   state;
  logic [TW-1:0] timer;
  logic          inc_q, dec_q, inc_armed, dec_armed, dir_up_q;
  logic          inc_rise, dec_rise, dir_valid, dir_same, timer_zero;

  // A key held through reset stays masked until it has been seen low once.
  assign inc_rise   = key_inc & ~inc_q & inc_armed;
  assign dec_rise   = key_dec & ~dec_q & dec_armed;
  assign dir_valid  = key_inc ^ key_dec;
  assign dir_same   = dir_valid && (key_inc == dir_up_q);
  assign timer_zero = (timer == '0);
  assign step_up    = key_inc;

  always_comb begin
    step = 1'b0;
    unique case (state)
      IDLE:         step = (inc_rise | dec_rise) & dir_valid;
      HOLD, REPEAT: step = dir_same & timer_zero;
      default:      step = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      inc_armed <= 1'b0;
      dec_armed <= 1'b0;
      dir_up_q  <= 1'b0;
    end else begin
      inc_q     <= key_inc;
      dec_q     <= key_dec;
      inc_armed <= inc_armed | ~key_inc;
      dec_armed <= dec_armed | ~key_dec;
      unique case (state)
        IDLE: begin
          if (step) begin
            timer    <= TW'(REPEAT_DELAY - 1);
            dir_up_q <= key_inc;
            state    <= HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!dir_same) begin
            state <= IDLE;
          end else if (timer_zero) begin
            timer <= TW'(REPEAT_PERIOD - 1);
            state <= REPEAT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rotation_ctrl.sv
// Button-to-display control: shadow/active rotation angle applied at frame start, mode index, frame counter.
module rotation_ctrl
  import rotation_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned NUM_MODES     = 8,
  parameter int unsigned CNT_MAX       = 99
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_inc,
  input  logic       i_key_dec,
  input  logic       i_key_mode,
  input  logic       i_frame_start,
  output logic [5:0] o_deg,
  output logic [2:0] o_mode,
  output logic [6:0] o_counter,
  output logic       o_pending
);

  deg_t shadow, shadow_d, deg_d;
  logic step, step_up;
  logic mode_q, mode_armed, mode_rise;

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_key_repeat (
    .clk    (i_clk),
    .rst    (i_rst),
    .key_inc(i_key_inc),
    .key_dec(i_key_dec),
    .step   (step),
    .step_up(step_up)
  );

  assign mode_rise = i_key_mode & ~mode_q & mode_armed;

  // Frame start applies the shadow as it stood before this edge; a coincident step waits a frame.
  always_comb begin
    shadow_d = shadow;
    if (step) shadow_d = step_up ? shadow + deg_t'(1) : shadow - deg_t'(1);
    deg_d = i_frame_start ? shadow : deg_t'(o_deg);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow     <= '0;
      o_deg      <= '0;
      o_pending  <= 1'b0;
      o_mode     <= '0;
      o_counter  <= '0;
      mode_q     <= 1'b0;
      mode_armed <= 1'b0;
    end else begin
      shadow     <= shadow_d;
      o_deg      <= deg_d;
      o_pending  <= (shadow_d != deg_d);
      mode_q     <= i_key_mode;
      mode_armed <= mode_armed | ~i_key_mode;
      if (mode_rise)
        o_mode <= (o_mode == mode_t'(NUM_MODES - 1)) ? '0 : o_mode + 1'b1;
      if (i_frame_start)
        o_counter <= (o_counter == cnt_t'(CNT_MAX)) ? '0 : o_counter + 1'b1;
    end
  end

endmodule

// File: tb/tb_rotation_ctrl.sv
// Directed self-checking bench for rotation_ctrl with short repeat timing.
module tb_rotation_ctrl;

  logic       clk = 1'b0;
  logic       rst, key_inc, key_dec, key_mode, frame_start;
  logic [5:0] deg;
  logic [2:0] mode;
  logic [6:0] counter;
  logic       pending;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  rotation_ctrl #(
    .REPEAT_DELAY (4),
    .REPEAT_PERIOD(2),
    .NUM_MODES    (8),
    .CNT_MAX      (99)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_inc    (key_inc),
    .i_key_dec    (key_dec),
    .i_key_mode   (key_mode),
    .i_frame_start(frame_start),
    .o_deg        (deg),
    .o_mode       (mode),
    .o_counter    (counter),
    .o_pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_cnt = (exp_cnt == 99) ? 0 : exp_cnt + 1;
    chk("counter", {1'b0, counter}, 8'(exp_cnt));
  endtask

  task automatic press_inc();
    key_inc = 1'b1; tick();
    key_inc = 1'b0; tick();
  endtask

  task automatic press_dec();
    key_dec = 1'b1; tick();
    key_dec = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; key_inc = 1'b1; key_dec = 1'b0; key_mode = 1'b0; frame_start = 1'b0;
    tick(); tick();
    chk("rst_deg", {2'b0, deg}, 8'd0);
    chk("rst_mode", {5'b0, mode}, 8'd0);
    chk("rst_counter", {1'b0, counter}, 8'd0);
    chk("rst_pending", {7'b0, pending}, 8'd0);

    // inc held across reset release: masked until seen low
    rst = 1'b0;
    tick(); tick(); tick();
    chk("held_no_step", {7'b0, pending}, 8'd0);
    key_inc = 1'b0; tick();
    key_inc = 1'b1; tick();
    chk("single_pending", {7'b0, pending}, 8'd1);
    chk("single_deg_before", {2'b0, deg}, 8'd0);
    key_inc = 1'b0; tick();
    frame_pulse();
    chk("single_deg_applied", {2'b0, deg}, 8'd1);
    chk("single_pending_clr", {7'b0, pending}, 8'd0);

    // auto-repeat from shadow 0: steps at press edge +0,4,6,8,10
    press_dec();
    frame_pulse();
    chk("deg_zero", {2'b0, deg}, 8'd0);
    key_inc = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    key_inc = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("repeat_pending", {7'b0, pending}, 8'd1);
    frame_pulse();
    chk("repeat_deg", {2'b0, deg}, 8'd5);
    chk("repeat_pending_clr", {7'b0, pending}, 8'd0);

    // wrap
    for (int i = 0; i < 5; i++) press_dec();
    frame_pulse();
    chk("back_to_zero", {2'b0, deg}, 8'd0);
    press_dec();
    frame_pulse();
    chk("wrap_down", {2'b0, deg}, 8'd63);
    press_inc();
    frame_pulse();
    chk("wrap_up", {2'b0, deg}, 8'd0);

    // both keys rise together: no step
    key_inc = 1'b1; key_dec = 1'b1; tick(); tick();
    key_inc = 1'b0; key_dec = 1'b0; tick();
    chk("both_pending", {7'b0, pending}, 8'd0);
    frame_pulse();
    chk("both_deg", {2'b0, deg}, 8'd0);

    // dec raised during HOLD exits to IDLE without stepping
    key_inc = 1'b1; tick(); tick();
    key_dec = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    key_dec = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    key_inc = 1'b0; tick();
    frame_pulse();
    chk("hold_cancel_deg", {2'b0, deg}, 8'd1);

    // step coinciding with frame start
    for (int i = 0; i < 6; i++) press_inc();
    frame_pulse();
    chk("collide_pre", {2'b0, deg}, 8'd7);
    key_inc = 1'b1; frame_start = 1'b1; tick();
    exp_cnt = (exp_cnt == 99) ? 0 : exp_cnt + 1;
    chk("collide_deg", {2'b0, deg}, 8'd7);
    chk("collide_pending", {7'b0, pending}, 8'd1);
    key_inc = 1'b0; frame_start = 1'b0; tick();
    frame_pulse();
    chk("collide_applied", {2'b0, deg}, 8'd8);
    chk("collide_pending_clr", {7'b0, pending}, 8'd0);

    // reset mid-hold, key kept high afterwards
    key_inc = 1'b1; tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0; exp_cnt = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("midhold_deg", {2'b0, deg}, 8'd0);
    chk("midhold_pending", {7'b0, pending}, 8'd0);
    chk("midhold_counter", {1'b0, counter}, 8'd0);
    key_inc = 1'b0; tick();

    // mode wraps at NUM_MODES-1
    for (int i = 0; i < 9; i++) begin
      key_mode = 1'b1; tick();
      chk("mode", {5'b0, mode}, 8'((i + 1) % 8));
      key_mode = 1'b0; tick();
    end

    // 101 frames from 0: through 99, wrap to 0, end at 1
    for (int i = 0; i < 101; i++) frame_pulse();
    chk("counter_final", {1'b0, counter}, 8'd1);
    chk("mode_unaffected", {5'b0, mode}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
